board_lcd_writer: RTL and testbench



---
 rtl/board_lcd_writer_pkg.sv | 52 +++++
 rtl/board_lcd_writer_lcd_bus_cycle.sv | 92 +++++++++
 rtl/board_lcd_writer.sv | 198 +++++++++++++++++++
 tb/tb_board_lcd_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_lcd_writer_pkg.sv
// Shared constants and types for the board LCD writer: HD44780 commands,
// glyphs, controller state codes and the writer's FSM encodings.
package board_lcd_writer_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        CS_IDLE       = 3'd0,
        CS_INIT_1     = 3'd1,
        CS_PEND_INIT  = 3'd2,
        CS_INIT_2     = 3'd3,
        CS_WAIT_PRESS = 3'd4,
        CS_PENDING    = 3'd5,
        CS_CHECK      = 3'd6,
        CS_ENDED      = 3'd7
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ST_POWERUP, ST_INIT, ST_IDLE, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_DONE
    } writer_state_e;

    typedef enum logic [2:0] {
        P_IDLE, P_SETUP, P_EHIGH, P_HOLD, P_WAIT
    } bus_phase_e;

    typedef struct packed {
        logic [63:0] board;
        logic [19:0] score;
        logic [2:0]  ctrl;
    } snapshot_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = LCD_FUNC_SET;
            3'd2:       init_cmd = LCD_DISP_ON;
            3'd3:       init_cmd = LCD_ENTRY;
            default:    init_cmd = LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/board_lcd_writer_lcd_bus_cycle.sv
// One HD44780 write cycle: setup, E pulse, hold, then the post-command wait.
module lcd_bus_cycle
    import board_lcd_writer_pkg::*;
#(
    parameter int unsigned E_HIGH_CYCLES     = 50,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    input  logic       i_long_wait,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data
);

    bus_phase_e       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_wait_last;
    logic             r_ready;
    logic             r_done;
    logic             r_rs;
    logic             r_e;
    logic [7:0]       r_data;

    // rs/data are only loaded in P_IDLE, so they are frozen for the whole E pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase     <= P_IDLE;
            r_cnt       <= '0;
            r_wait_last <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_rs        <= 1'b0;
            r_e         <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_phase)
                P_IDLE: begin
                    if (i_start && r_ready) begin
                        r_rs        <= i_rs;
                        r_data      <= i_byte;
                        r_wait_last <= i_long_wait ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                                                   : CNT_W'(CMD_WAIT_CYCLES - 1);
                        r_ready     <= 1'b0;
                        r_phase     <= P_SETUP;
                    end
                end
                P_SETUP: begin
                    r_e     <= 1'b1;
                    r_cnt   <= '0;
                    r_phase <= P_EHIGH;
                end
                P_EHIGH: begin
                    if (r_cnt == CNT_W'(E_HIGH_CYCLES - 1)) begin
                        r_e     <= 1'b0;
                        r_phase <= P_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                P_HOLD: begin
                    r_cnt   <= '0;
                    r_phase <= P_WAIT;
                end
                P_WAIT: begin
                    if (r_cnt == r_wait_last) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_phase <= P_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_phase <= P_IDLE;
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_done     = r_done;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_e    = r_e;
    assign o_lcd_data = r_data;

endmodule

// File: rtl/board_lcd_writer.sv
// Renders the 4x4 board, BCD score and controller state on a 16x2 HD44780 LCD,
// redrawing a full frame whenever any displayed input changes.
module board_lcd_writer
    import board_lcd_writer_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 2000000,
    parameter int unsigned E_HIGH_CYCLES     = 50,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] total_current_state,
    input  logic [19:0] score,
    input  logic [2:0]  state,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        init_done,
    output logic        frame_done
);

    function automatic logic [7:0] tile_char(input logic [3:0] n);
        if (n == 4'd0)       tile_char = CH_DOT;
        else if (n <= 4'd9)  tile_char = 8'h30 + {4'h0, n};
        else                 tile_char = 8'h41 + {4'h0, n - 4'd10};
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        digit_char = (d <= 4'd9) ? (8'h30 + {4'h0, d}) : CH_QMARK;
    endfunction

    function automatic logic [31:0] status_word(input logic [2:0] st);
        case (st)
            CS_WAIT_PRESS:         status_word = "PLAY";
            CS_PENDING, CS_CHECK:  status_word = "MOVE";
            CS_ENDED:              status_word = "OVER";
            default:               status_word = "INIT";
        endcase
    endfunction

    function automatic logic [7:0] line2_char(input logic [3:0] col, input logic [19:0] sc,
                                              input logic [2:0] st);
        logic [31:0] word;
        word = status_word(st);
        case (col)
            4'd0:    line2_char = 8'h53;
            4'd1:    line2_char = 8'h43;
            4'd2:    line2_char = 8'h3A;
            4'd3:    line2_char = digit_char(sc[19:16]);
            4'd4:    line2_char = digit_char(sc[15:12]);
            4'd5:    line2_char = digit_char(sc[11:8]);
            4'd6:    line2_char = digit_char(sc[7:4]);
            4'd7:    line2_char = digit_char(sc[3:0]);
            4'd12:   line2_char = word[31:24];
            4'd13:   line2_char = word[23:16];
            4'd14:   line2_char = word[15:8];
            4'd15:   line2_char = word[7:0];
            default: line2_char = CH_SPACE;
        endcase
    endfunction

    writer_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_init_idx;
    logic [3:0]       r_col;
    logic             r_start;
    logic             r_busy;
    logic             r_have_snap;
    snapshot_t        r_snap;
    logic             r_init_done;
    logic             r_frame_done;

    snapshot_t        w_live;
    logic             w_ready;
    logic             w_done;
    logic             w_rs;
    logic [7:0]       w_byte;
    logic             w_long_wait;

    assign w_live = '{board: total_current_state, score: score, ctrl: state};

    // Byte for the current step, rendered from the snapshot only
    always_comb begin
        w_rs   = 1'b0;
        w_byte = 8'h00;
        case (r_state)
            ST_INIT:  w_byte = init_cmd(r_init_idx);
            ST_ADDR1: w_byte = LCD_LINE1;
            ST_LINE1: begin
                w_rs   = 1'b1;
                w_byte = tile_char(r_snap.board[{4'd15 - r_col, 2'b00} +: 4]);
            end
            ST_ADDR2: w_byte = LCD_LINE2;
            ST_LINE2: begin
                w_rs   = 1'b1;
                w_byte = line2_char(r_col, r_snap.score, r_snap.ctrl);
            end
            default: ;
        endcase
    end

    assign w_long_wait = !w_rs && (w_byte == LCD_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_POWERUP;
            r_cnt        <= '0;
            r_init_idx   <= 3'd0;
            r_col        <= 4'd0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_have_snap  <= 1'b0;
            r_snap       <= '0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_POWERUP: begin
                    if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!r_have_snap || (w_live != r_snap)) begin
                        r_snap      <= w_live;
                        r_have_snap <= 1'b1;
                        r_state     <= ST_ADDR1;
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    // Issue one byte, then advance when the bus cycle reports done
                    if (!r_busy && w_ready) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (r_busy && w_done) begin
                        r_busy <= 1'b0;
                        case (r_state)
                            ST_INIT: begin
                                if (r_init_idx == 3'd4) begin
                                    r_init_idx  <= 3'd0;
                                    r_init_done <= 1'b1;
                                    r_state     <= ST_IDLE;
                                end else begin
                                    r_init_idx <= r_init_idx + 3'd1;
                                end
                            end
                            ST_ADDR1: r_state <= ST_LINE1;
                            ST_ADDR2: r_state <= ST_LINE2;
                            ST_LINE1: begin
                                r_col <= r_col + 4'd1;
                                if (r_col == 4'd15) r_state <= ST_ADDR2;
                            end
                            ST_LINE2: begin
                                r_col <= r_col + 4'd1;
                                if (r_col == 4'd15) r_state <= ST_DONE;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_HIGH_CYCLES     (E_HIGH_CYCLES),
        .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .i_start     (r_start),
        .i_rs        (w_rs),
        .i_byte      (w_byte),
        .i_long_wait (w_long_wait),
        .o_ready     (w_ready),
        .o_done      (w_done),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_e     (lcd_e),
        .o_lcd_data  (lcd_data)
    );

    assign lcd_rw     = 1'b0;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_board_lcd_writer.sv
// Directed bench for board_lcd_writer: init sequence, frame contents, redraw
// behaviour, mid-frame reset, plus a continuous bus protocol monitor.
module tb_board_lcd_writer;

    logic        clk;
    logic        rst;
    logic [63:0] board;
    logic [19:0] score;
    logic [2:0]  st;
    logic        lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data;
    logic        init_done, frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_frames = 0;
    int init_t   = 0;
    int c0       = 0;

    logic [8:0] bytes[$];
    int         rise_t[$];
    int         fall_t[$];

    board_lcd_writer #(
        .POWERUP_CYCLES    (20),
        .E_HIGH_CYCLES     (3),
        .CMD_WAIT_CYCLES   (5),
        .CLEAR_WAIT_CYCLES (12)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .total_current_state (board),
        .score               (score),
        .state               (st),
        .lcd_rs              (lcd_rs),
        .lcd_rw              (lcd_rw),
        .lcd_e               (lcd_e),
        .lcd_data            (lcd_data),
        .init_done           (init_done),
        .frame_done          (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: captures every byte and checks E width and data stability
    initial begin
        logic       prev_e;
        logic [8:0] held;
        int         e_len;
        prev_e = 1'b0;
        held   = '0;
        e_len  = 0;
        forever begin
            @(negedge clk);
            if (lcd_e && !prev_e) begin
                rise_t.push_back(cyc);
                held = {lcd_rs, lcd_data};
                bytes.push_back(held);
                e_len = 1;
                expect_eq("rw_low", 128'(lcd_rw), 128'(0));
            end else if (lcd_e) begin
                e_len++;
                expect_eq("bus_stable", 128'({lcd_rs, lcd_data}), 128'(held));
            end else if (prev_e) begin
                fall_t.push_back(cyc);
                if (rst) expect_eq("e_width", 128'(e_len), 128'(3));
            end
            if (frame_done) n_frames++;
            prev_e = lcd_e;
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        c0  = cyc;
    endtask

    task automatic wait_init(input string tag);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (init_done) break;
        end
        init_t = cyc;
        expect_eq({tag, "_seen"}, 128'(init_done), 128'(1));
    endtask

    task automatic wait_frame(input string tag);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        expect_eq({tag, "_seen"}, 128'(frame_done), 128'(1));
    endtask

    task automatic wait_bytes(input int n, input string tag);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bytes.size() >= n) break;
        end
        expect_eq(tag, 128'(bytes.size() >= n), 128'(1));
    endtask

    task automatic check_init(input string tag);
        logic [44:0] got;
        int          pu_gap, clr_gap;
        got = '0; pu_gap = 0; clr_gap = 0;
        expect_eq({tag, "_count"}, 128'(bytes.size() >= 5), 128'(1));
        if (bytes.size() >= 5 && fall_t.size() >= 5) begin
            got     = {bytes[0], bytes[1], bytes[2], bytes[3], bytes[4]};
            pu_gap  = rise_t[0] - c0;
            clr_gap = init_t - fall_t[4];
        end
        expect_eq({tag, "_cmds"}, 128'(got), 128'({9'h038, 9'h038, 9'h00C, 9'h006, 9'h001}));
        expect_eq({tag, "_powerup_gap"}, 128'(pu_gap >= 20), 128'(1));
        expect_eq({tag, "_clear_gap"}, 128'(clr_gap >= 13), 128'(1));
    endtask

    task automatic check_frame(input int base, input string tag,
                               input logic [127:0] l1, input logic [127:0] l2);
        logic [127:0] g1, g2;
        logic [17:0]  addrs;
        logic         rs_all;
        g1 = '0; g2 = '0; addrs = '0; rs_all = 1'b0;
        expect_eq({tag, "_len"}, 128'(bytes.size() >= base + 34), 128'(1));
        if (bytes.size() >= base + 34) begin
            rs_all = 1'b1;
            addrs  = {bytes[base], bytes[base + 17]};
            for (int i = 0; i < 16; i++) begin
                g1[8*(15-i) +: 8] = bytes[base + 1 + i][7:0];
                g2[8*(15-i) +: 8] = bytes[base + 18 + i][7:0];
                rs_all &= bytes[base + 1 + i][8] & bytes[base + 18 + i][8];
            end
        end
        expect_eq({tag, "_addr"}, 128'(addrs), 128'({9'h080, 9'h0C0}));
        expect_eq({tag, "_rs_data"}, 128'(rs_all), 128'(1));
        expect_eq({tag, "_line1"}, g1, l1);
        expect_eq({tag, "_line2"}, g2, l2);
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        board = 64'h0123_4567_89AB_CDEF;
        score = 20'h02048;
        st    = 3'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_eq("reset_outputs",
                  128'({lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done}), 128'(0));

        release_reset();
        wait_init("init1");
        check_init("init1");
        wait_frame("frame1");
        check_frame(5, "frame1", ".123456789ABCDEF", "SC:02048    PLAY");

        n = rise_t.size();
        repeat (1000) @(negedge clk);
        expect_eq("idle_no_e", 128'(rise_t.size()), 128'(n));
        expect_eq("one_frame_pulse", 128'(n_frames), 128'(1));

        // Controller state changes while line 1 is being written
        @(posedge clk); #1;
        bytes.delete();
        score = 20'h00001;
        wait_bytes(5, "line1_reached");
        @(posedge clk); #1;
        st = 3'd7;
        wait_frame("frame2");
        check_frame(0, "frame2", ".123456789ABCDEF", "SC:00001    PLAY");
        wait_frame("frame3");
        check_frame(34, "frame3", ".123456789ABCDEF", "SC:00001    OVER");
        expect_eq("frame_count", 128'(n_frames), 128'(3));

        @(posedge clk); #1;
        bytes.delete();
        board = 64'hF000_0000_0000_0001;
        score = 20'hA0000;
        wait_frame("frame4");
        check_frame(0, "frame4", "F..............1", "SC:?0000    OVER");

        // Reset while E is high in line 2
        @(posedge clk); #1;
        bytes.delete();
        st = 3'd5;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (lcd_e && bytes.size() >= 20) break;
        end
        expect_eq("abort_in_line2", 128'(lcd_e), 128'(1));
        rst = 1'b0;
        @(negedge clk);
        expect_eq("abort_outputs",
                  128'({lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done}), 128'(0));
        repeat (2) @(negedge clk);
        bytes.delete();
        rise_t.delete();
        fall_t.delete();
        release_reset();
        wait_init("init2");
        check_init("init2");
        wait_frame("frame5");
        check_frame(5, "frame5", "F..............1", "SC:?0000    MOVE");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
